// File: rtl/reorder_buffer.sv
// In-order commit queue: 2-wide allocate, 3-port completion with wakeup broadcast, 2-wide in-order retire.
// Optional macro ROB_RETIRE_BYPASS_EN lets a same-edge completion at head (or head+1) retire immediately.
package reorder_buffer_pkg;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned ALLOC_W  = 2;
    localparam int unsigned COMP_W   = 3;
    localparam int unsigned RETIRE_W = 2;
    localparam int unsigned ROB_W    = 4;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned PREG_W   = 6;
    localparam int unsigned DATA_W   = 32;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [ROB_W-1:0]  ROBNumber;
        logic [PREG_W-1:0] PRegAddrDst;
        logic [PREG_W-1:0] OldPRegAddrDst;
        logic [DATA_W-1:0] data;
    } rob_row_struct;
endpackage

module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  rob_row_struct    i_alloc_rows        [ALLOC_W],
    output logic             o_full,
    input  rob_row_struct    i_fu_results        [COMP_W],
    output rob_row_struct    o_complete_rob_rows [COMP_W],
    output rob_row_struct    o_retire            [RETIRE_W],
    output logic [CNT_W-1:0] o_count,
    output logic [ROB_W-1:0] o_head,
    output logic             o_err
);

    rob_row_struct    entries_q [DEPTH];
    rob_row_struct    entries_c [DEPTH];
    rob_row_struct    entries_d [DEPTH];
    rob_row_struct    ret_view  [DEPTH];
    rob_row_struct    comp_q    [COMP_W];
    rob_row_struct    comp_d    [COMP_W];
    rob_row_struct    retire_q  [RETIRE_W];
    rob_row_struct    retire_d  [RETIRE_W];
    logic [ROB_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, err_q, err_d, comp_err;
    logic             dup, ret_go, live_any;
    logic [ROB_W-1:0] cidx, ridx;
    logic [1:0]       alloc_cnt, ret_cnt;
    rob_row_struct    alloc_row;

    // Completion: lowest port wins on duplicates; bad targets flag an error
    always_comb begin
        entries_c = entries_q;
        comp_d    = '{default: '0};
        comp_err  = 1'b0;
        dup       = 1'b0;
        cidx      = '0;
        for (int p = 0; p < int'(COMP_W); p++) begin
            dup  = 1'b0;
            cidx = i_fu_results[p].ROBNumber;
            for (int q = 0; q < p; q++) begin
                if (i_fu_results[q].valid && (i_fu_results[q].ROBNumber == cidx)) begin
                    dup = 1'b1;
                end
            end
            if (i_fu_results[p].valid && !dup) begin
                if (entries_q[cidx].valid && !entries_q[cidx].complete) begin
                    entries_c[cidx].complete = 1'b1;
                    entries_c[cidx].data     = i_fu_results[p].data;
                    comp_d[p]                = entries_c[cidx];
                end else begin
                    comp_err = 1'b1;
                end
            end
        end
    end

`ifdef ROB_RETIRE_BYPASS_EN
    assign ret_view = entries_c;
`else
    assign ret_view = entries_q;
`endif

    // Retire then allocate; allocation only ever targets free slots, so no overlap with retire
    always_comb begin
        entries_d = entries_c;
        retire_d  = '{default: '0};
        head_d    = head_q;
        tail_d    = tail_q;
        err_d     = err_q | comp_err;
        ret_go    = 1'b1;
        ret_cnt   = '0;
        alloc_cnt = '0;
        ridx      = '0;
        alloc_row = '0;
        live_any  = 1'b0;

        for (int s = 0; s < int'(RETIRE_W); s++) begin
            ridx = head_q + ROB_W'(s);
            if (ret_go && ret_view[ridx].valid && ret_view[ridx].complete) begin
                retire_d[s]               = ret_view[ridx];
                entries_d[ridx].valid     = 1'b0;
                entries_d[ridx].complete  = 1'b0;
                ret_cnt                   = ret_cnt + 2'd1;
            end else begin
                ret_go = 1'b0;
            end
        end
        head_d = head_q + ROB_W'(ret_cnt);

        for (int s = 0; s < int'(ALLOC_W); s++) begin
            live_any = live_any | i_alloc_rows[s].valid;
        end

        if (full_q && live_any) begin
            err_d = 1'b1;
        end else begin
            for (int s = 0; s < int'(ALLOC_W); s++) begin
                if (i_alloc_rows[s].valid) begin
                    if (i_alloc_rows[s].ROBNumber != tail_d) begin
                        err_d = 1'b1;
                    end
                    alloc_row           = i_alloc_rows[s];
                    alloc_row.valid     = 1'b1;
                    alloc_row.complete  = 1'b0;
                    alloc_row.ROBNumber = tail_d;
                    alloc_row.data      = '0;
                    entries_d[tail_d]   = alloc_row;
                    tail_d              = tail_d + ROB_W'(1);
                    alloc_cnt           = alloc_cnt + 2'd1;
                end
            end
        end

        count_d = count_q + CNT_W'(alloc_cnt) - CNT_W'(ret_cnt);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            for (int p = 0; p < int'(COMP_W); p++) begin
                comp_q[p] <= '0;
            end
            for (int s = 0; s < int'(RETIRE_W); s++) begin
                retire_q[s] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            entries_q <= entries_d;
            comp_q    <= comp_d;
            retire_q  <= retire_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_q    <= (count_d > CNT_W'(DEPTH - ALLOC_W));
            err_q     <= err_d;
        end
    end

    assign o_full              = full_q;
    assign o_err               = err_q;
    assign o_count             = count_q;
    assign o_head              = head_q;
    assign o_complete_rob_rows = comp_q;
    assign o_retire            = retire_q;

    // Fields of the input rows that the queue never consumes
    logic unused_fields;
    assign unused_fields = ^{i_alloc_rows[0].complete, i_alloc_rows[0].data,
                             i_alloc_rows[1].complete, i_alloc_rows[1].data,
                             i_fu_results[0].complete, i_fu_results[0].PRegAddrDst, i_fu_results[0].OldPRegAddrDst,
                             i_fu_results[1].complete, i_fu_results[1].PRegAddrDst, i_fu_results[1].OldPRegAddrDst,
                             i_fu_results[2].complete, i_fu_results[2].PRegAddrDst, i_fu_results[2].OldPRegAddrDst};

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retire order queued at allocation, data recorded at completion.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

`ifdef ROB_RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [3:0] rob;
        logic [5:0] old;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    rob_row_struct alloc_rows [ALLOC_W];
    rob_row_struct fu         [COMP_W];
    rob_row_struct comp       [COMP_W];
    rob_row_struct ret        [RETIRE_W];
    logic          full, err;
    logic [4:0]    count;
    logic [3:0]    head;

    exp_t          exp_q [$];
    exp_t          e;
    logic [31:0]   exp_data [16];
    logic [3:0]    tb_tail;
    logic [3:0]    prev_head = '0;
    bit            wrap_seen;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_retired = 0;

    reorder_buffer dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_alloc_rows        (alloc_rows),
        .o_full              (full),
        .i_fu_results        (fu),
        .o_complete_rob_rows (comp),
        .o_retire            (ret),
        .o_count             (count),
        .o_head              (head),
        .o_err               (err)
    );

    always #5 i_clk = ~i_clk;

    // Retire scoreboard: every retired row must be the next expected one, with its completed data
    always @(negedge i_clk) begin
        if (!i_rst) begin
            for (int s = 0; s < 2; s++) begin
                if (ret[s].valid) begin
                    n_retired++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL retire_unexpected slot%0d: got rob %0d, required no retire", s, ret[s].ROBNumber);
                    end else begin
                        e = exp_q.pop_front();
                        if (ret[s].ROBNumber !== e.rob || ret[s].OldPRegAddrDst !== e.old ||
                            ret[s].data !== exp_data[e.rob]) begin
                            n_fail++;
                            $display("FAIL retire_row slot%0d: got rob %0d old %0d data %h, required rob %0d old %0d data %h",
                                     s, ret[s].ROBNumber, ret[s].OldPRegAddrDst, ret[s].data,
                                     e.rob, e.old, exp_data[e.rob]);
                        end
                    end
                end
            end
            if (head < prev_head) wrap_seen = 1'b1;
        end
        prev_head = head;
    end

    task automatic clear_in();
        for (int s = 0; s < 2; s++) alloc_rows[s] = '0;
        for (int p = 0; p < 3; p++) fu[p] = '0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        clear_in();
    endtask

    task automatic alloc_slot(input int s, input logic [5:0] dst, input logic [5:0] old, input bit track);
        exp_t x;
        alloc_rows[s]                = '0;
        alloc_rows[s].valid          = 1'b1;
        alloc_rows[s].ROBNumber      = tb_tail;
        alloc_rows[s].PRegAddrDst    = dst;
        alloc_rows[s].OldPRegAddrDst = old;
        if (track) begin
            x.rob = tb_tail;
            x.old = old;
            exp_q.push_back(x);
        end
        tb_tail = tb_tail + 4'd1;
    endtask

    task automatic fu_slot(input int p, input logic [3:0] rob, input logic [31:0] d, input bit track);
        fu[p]           = '0;
        fu[p].valid     = 1'b1;
        fu[p].ROBNumber = rob;
        fu[p].data      = d;
        if (track) exp_data[rob] = d;
    endtask

    task automatic do_reset();
        clear_in();
        i_rst = 1'b1;
        exp_q.delete();
        tb_tail = '0;
        for (int i = 0; i < 16; i++) exp_data[i] = '0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (count != 0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("FAIL drain_timeout: got count %0d, required 0", count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", count); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", full); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        n_cmp++; if (head !== 4'd0) begin n_fail++; $display("FAIL reset_head: got %0d, required 0", head); end
        n_cmp++;
        if (ret[0] !== '0 || ret[1] !== '0 || comp[0].valid !== 1'b0 || comp[1].valid !== 1'b0 || comp[2].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got retire %h/%h comp valids %b%b%b, required all zero",
                     ret[0], ret[1], comp[0].valid, comp[1].valid, comp[2].valid);
        end
    endtask

    task automatic test_basic();
        bit found;
        do_reset();
        alloc_slot(0, 6'd33, 6'd1, 1'b1);
        alloc_slot(1, 6'd34, 6'd2, 1'b1);
        tick();
        n_cmp++; if (count !== 5'd2) begin n_fail++; $display("FAIL basic_count_alloc: got %0d, required 2", count); end
        fu_slot(0, 4'd1, 32'h0000_AAAA, 1'b1);
        tick();
        n_cmp++;
        if (comp[0].valid !== 1'b1 || comp[0].complete !== 1'b1 || comp[0].ROBNumber !== 4'd1 ||
            comp[0].data !== 32'h0000_AAAA || comp[0].PRegAddrDst !== 6'd34 || comp[0].OldPRegAddrDst !== 6'd2) begin
            n_fail++;
            $display("FAIL basic_bcast_rob1: got %h, required rob1 dst34 old2 data aaaa", comp[0]);
        end
        fu_slot(1, 4'd0, 32'h0000_5555, 1'b1);
        tick();
        n_cmp++;
        if (comp[1].valid !== 1'b1 || comp[1].ROBNumber !== 4'd0 || comp[1].data !== 32'h0000_5555 ||
            comp[1].PRegAddrDst !== 6'd33 || comp[0].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_bcast_rob0: got slot1 %h slot0 valid %b, required rob0 dst33 data 5555, slot0 idle",
                     comp[1], comp[0].valid);
        end
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (ret[0].valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!found || ret[0].ROBNumber !== 4'd0 || ret[0].OldPRegAddrDst !== 6'd1 ||
            ret[1].valid !== 1'b1 || ret[1].ROBNumber !== 4'd1 || ret[1].OldPRegAddrDst !== 6'd2) begin
            n_fail++;
            $display("FAIL basic_retire_pair: got found %b s0 rob%0d old%0d s1 v%b rob%0d old%0d, required rob0 old1 + rob1 old2",
                     found, ret[0].ROBNumber, ret[0].OldPRegAddrDst, ret[1].valid, ret[1].ROBNumber, ret[1].OldPRegAddrDst);
        end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL basic_count_end: got %0d, required 0", count); end
    endtask

    task automatic test_latency();
        do_reset();
        alloc_slot(0, 6'd40, 6'd7, 1'b1);
        tick();
        fu_slot(0, 4'd0, 32'hCAFE_0001, 1'b1);
        tick();
        n_cmp++; if (comp[0].valid !== 1'b1) begin n_fail++; $display("FAIL lat_bcast: got %b, required 1", comp[0].valid); end
        n_cmp++; if (ret[0].valid !== BYP) begin n_fail++; $display("FAIL lat_retire_same: got %b, required %b", ret[0].valid, BYP); end
        tick();
        n_cmp++; if (ret[0].valid !== !BYP) begin n_fail++; $display("FAIL lat_retire_next: got %b, required %b", ret[0].valid, !BYP); end
        tick();
    endtask

    task automatic test_full();
        int base;
        logic [3:0] save;
        do_reset();
        base = n_retired;
        for (int i = 0; i < 8; i++) begin
            alloc_slot(0, 6'(20 + 2*i), 6'(2*i), 1'b1);
            alloc_slot(1, 6'(21 + 2*i), 6'(2*i + 1), 1'b1);
            tick();
            if (i == 6) begin
                n_cmp++;
                if (count !== 5'd14 || full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_at14: got count %0d full %b, required 14 / 0", count, full);
                end
            end
        end
        n_cmp++;
        if (count !== 5'd16 || full !== 1'b1 || head !== 4'd0) begin
            n_fail++;
            $display("FAIL full_at16: got count %0d full %b head %0d, required 16 / 1 / 0", count, full, head);
        end
        save = tb_tail;
        alloc_slot(0, 6'd60, 6'd61, 1'b0);
        tb_tail = save;
        tick();
        n_cmp++;
        if (count !== 5'd16 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drop: got count %0d err %b, required 16 / 1", count, err);
        end
        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (c*3 + p < 16) fu_slot(p, 4'(c*3 + p), 32'(32'hF00 + c*3 + p), 1'b1);
            end
            tick();
        end
        drain(40);
        tick();
        n_cmp++;
        if (n_retired - base !== 16 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain: got retired %0d err %b, required 16 / 1", n_retired - base, err);
        end
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        base = n_retired;
        wrap_seen = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                alloc_slot(0, 6'(i), 6'(32 + 2*i), 1'b1);
                alloc_slot(1, 6'(i), 6'(33 + 2*i), 1'b1);
            end
            if (i > 0) begin
                fu_slot(0, 4'(2*(i-1)), 32'(32'h100 + 2*(i-1)), 1'b1);
                fu_slot(1, 4'(2*(i-1) + 1), 32'(32'h101 + 2*(i-1)), 1'b1);
            end
            tick();
        end
        drain(20);
        tick();
        n_cmp++;
        if (n_retired - base !== 20 || head !== 4'd4 || !wrap_seen || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: got retired %0d head %0d wrapped %b err %b, required 20 / 4 / 1 / 0",
                     n_retired - base, head, wrap_seen, err);
        end
    endtask

    task automatic test_bad_completion();
        do_reset();
        fu_slot(0, 4'd7, 32'hDEAD_BEEF, 1'b0);
        tick();
        n_cmp++;
        if (comp[0].valid !== 1'b0 || err !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL invalid_rob: got bcast %b err %b count %0d, required 0 / 1 / 0", comp[0].valid, err, count);
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            alloc_slot(0, 6'(50 + 2*i), 6'(10 + 2*i), 1'b1);
            alloc_slot(1, 6'(51 + 2*i), 6'(11 + 2*i), 1'b1);
            tick();
        end
        fu_slot(0, 4'd3, 32'h0000_1111, 1'b1);
        fu_slot(2, 4'd3, 32'h0000_2222, 1'b0);
        tick();
        n_cmp++;
        if (comp[0].valid !== 1'b1 || comp[0].data !== 32'h0000_1111 || comp[0].ROBNumber !== 4'd3 ||
            comp[2].valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_rob3: got fu0 v%b data %h fu2 v%b err %b, required 1 / 1111 / 0 / 0",
                     comp[0].valid, comp[0].data, comp[2].valid, err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_slot(0, 6'd1, 6'd21, 1'b1);
        alloc_slot(1, 6'd2, 6'd22, 1'b1);
        tick();
        alloc_slot(0, 6'd3, 6'd23, 1'b1);
        alloc_slot(1, 6'd4, 6'd24, 1'b1);
        fu_slot(0, 4'd0, 32'h0000_0A00, 1'b1);
        tick();
        alloc_slot(0, 6'd5, 6'd25, 1'b1);
        fu_slot(0, 4'd1, 32'h0000_0A01, 1'b1);
        tick();
        i_rst = 1'b1;
        exp_q.delete();
        tick();
        n_cmp++;
        if (count !== 5'd0 || head !== 4'd0 || ret[0].valid !== 1'b0 || ret[1].valid !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got count %0d head %0d retire %b%b full %b, required 0 / 0 / 00 / 0",
                     count, head, ret[0].valid, ret[1].valid, full);
        end
        i_rst = 1'b0;
        tick();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_basic();
        test_latency();
        test_full();
        test_wrap();
        test_bad_completion();
        test_reset_mid();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d rows never retired, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
